// File: rtl/exp_pow2_pkg.sv
// Shared constants and shift-class encoding for the softmax exponent back end.
// The output width and fraction width are sized to match the output buffer's fixed-point format.
package exp_pow2_pkg;

    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int FIXPOINT_FRAC       = 10;
    localparam int SHAMT_W             = 5;

    typedef enum logic [1:0] {
        SHIFT_SAT   = 2'd0,
        SHIFT_ZERO  = 2'd1,
        SHIFT_LEFT  = 2'd2,
        SHIFT_RIGHT = 2'd3
    } shift_cls_e;

endpackage

// File: rtl/exp_pow2_if.sv
// Element input, per-element result output and row-sum output of exp_pow2.
// The slave modport is the exp_pow2 side; the master modport is the producer/consumer side.
interface exp_pow2_if #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 10
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] u;
    logic [FRAC_W-1:0] v;
    logic              in_last;
    logic              is_stage2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sum_valid;
    logic [DATA_W-1:0] sum_out;

    modport slave (
        input  in_valid, u, v, in_last, is_stage2, out_ready,
        output in_ready, out_valid, out_data, sum_valid, sum_out
    );

    modport master (
        output in_valid, u, v, in_last, is_stage2, out_ready,
        input  in_ready, out_valid, out_data, sum_valid, sum_out
    );

endinterface

// File: rtl/exp_pow2_pow2_shift.sv
// Combinational shifter: scales the 1.FRAC_W mantissa by 2^amt according to the shift class.
// The mantissa is widened first so that the largest left shift still fits.
module pow2_shift
    import exp_pow2_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC
) (
    input  logic [FRAC_W:0]      m,
    input  shift_cls_e           cls,
    input  logic [SHAMT_W-1:0]   amt,
    output logic [DATA_W-1:0]    result
);

    logic [DATA_W-1:0] m_wide;

    always_comb begin
        m_wide = {{(DATA_W-FRAC_W-1){1'b0}}, m};
        case (cls)
            SHIFT_LEFT:  result = m_wide << amt;
            SHIFT_RIGHT: result = m_wide >> amt;
            SHIFT_SAT:   result = '1;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/exp_pow2.sv
// Reconstructs 2^(u+v) ~ (1+v)*2^u in 22.10 fixed point through two pipeline registers.
// Stage-2 elements are summed per row into sum_out; stage-4 elements stream out on out_*.
module exp_pow2
    import exp_pow2_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC
) (
    input  logic      clk,
    input  logic      rst,
    exp_pow2_if.slave bus
);

    localparam logic signed [DATA_W-1:0] SAT_LIMIT   = DATA_W'(DATA_W - FRAC_W - 1);
    localparam logic signed [DATA_W-1:0] RIGHT_LIMIT = DATA_W'(-FRAC_W);

    logic               s1_valid_q, s1_valid_d;
    logic [FRAC_W:0]    s1_m_q, s1_m_d;
    shift_cls_e         s1_cls_q, s1_cls_d;
    logic [SHAMT_W-1:0] s1_amt_q, s1_amt_d;
    logic               s1_last_q, s1_last_d;
    logic               s1_stage2_q, s1_stage2_d;

    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_res_q, s2_res_d;
    logic               s2_last_q, s2_last_d;
    logic               s2_stage2_q, s2_stage2_d;

    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  sum_out_q, sum_out_d;
    logic               sum_valid_q, sum_valid_d;

    shift_cls_e         cls_in;
    logic [SHAMT_W-1:0] amt_in;
    logic [DATA_W-1:0]  neg_u;
    logic [DATA_W-1:0]  shift_res;
    logic               s2_drain, s2_adv, s1_adv;
    logic [DATA_W:0]    acc_sum;
    logic [DATA_W-1:0]  acc_next;

    // Classify the full-width exponent here so only a 5-bit amount reaches the shifter.
    always_comb begin
        cls_in = SHIFT_ZERO;
        amt_in = '0;
        neg_u  = '0 - bus.u;
        if ($signed(bus.u) >= SAT_LIMIT) begin
            cls_in = SHIFT_SAT;
        end else if (!bus.u[DATA_W-1]) begin
            cls_in = SHIFT_LEFT;
            amt_in = bus.u[SHAMT_W-1:0];
        end else if ($signed(bus.u) >= RIGHT_LIMIT) begin
            cls_in = SHIFT_RIGHT;
            amt_in = neg_u[SHAMT_W-1:0];
        end
    end

    pow2_shift #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_shift (
        .m      (s1_m_q),
        .cls    (s1_cls_q),
        .amt    (s1_amt_q),
        .result (shift_res)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and data is held while valid is high and ready is low.
    always_comb begin
        s2_drain = s2_valid_q && (s2_stage2_q || bus.out_ready);
        s2_adv   = !s2_valid_q || s2_drain;
        s1_adv   = !s1_valid_q || s2_adv;
        acc_sum  = {1'b0, acc_q} + {1'b0, s2_res_q};
        acc_next = acc_sum[DATA_W] ? '1 : acc_sum[DATA_W-1:0];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_m_d      = s1_m_q;
        s1_cls_d    = s1_cls_q;
        s1_amt_d    = s1_amt_q;
        s1_last_d   = s1_last_q;
        s1_stage2_d = s1_stage2_q;
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_last_d   = s2_last_q;
        s2_stage2_d = s2_stage2_q;
        acc_d       = acc_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = 1'b0;

        if (s1_adv) begin
            s1_valid_d  = bus.in_valid;
            s1_m_d      = {1'b1, bus.v};
            s1_cls_d    = cls_in;
            s1_amt_d    = amt_in;
            s1_last_d   = bus.in_last;
            s1_stage2_d = bus.is_stage2;
        end

        if (s2_adv) begin
            s2_valid_d  = s1_valid_q;
            s2_res_d    = shift_res;
            s2_last_d   = s1_last_q;
            s2_stage2_d = s1_stage2_q;
        end

        // The accumulator only sees the element leaving S2, so a new row entering S2 on
        // the same edge as the old row's last drain always starts from zero.
        if (s2_drain && s2_stage2_q) begin
            if (s2_last_q) begin
                sum_out_d   = acc_next;
                sum_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d       = acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_m_q      <= '0;
            s1_cls_q    <= SHIFT_ZERO;
            s1_amt_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_stage2_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_last_q   <= 1'b0;
            s2_stage2_q <= 1'b0;
            acc_q       <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_m_q      <= s1_m_d;
            s1_cls_q    <= s1_cls_d;
            s1_amt_q    <= s1_amt_d;
            s1_last_q   <= s1_last_d;
            s1_stage2_q <= s1_stage2_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_last_q   <= s2_last_d;
            s2_stage2_q <= s2_stage2_d;
            acc_q       <= acc_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q && !s2_stage2_q;
    assign bus.out_data  = s2_res_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_out   = sum_out_q;

endmodule

// File: tb/tb_exp_pow2.sv
// Scoreboarded bench for exp_pow2: directed values, stage-2 row sums, backpressure,
// mid-row reset and a long random stream against an arithmetic reference model.
module tb_exp_pow2;
    import exp_pow2_pkg::*;

    localparam int DW = 32;
    localparam int FW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exp_pow2_if #(.DATA_W(DW), .FRAC_W(FW)) bus ();

    exp_pow2 #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sum_q[$];
    int            sum_cyc_q[$];

    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_acc = 0;
    logic          rand_rdy = 1'b0;
    longint        row_acc = 0;
    logic [DW-1:0] last_sum = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: (1 + v/2^FW) * 2^u in 22.10, saturating above 2^32-1, truncating below.
    function automatic logic [DW-1:0] ref_exp(input logic [DW-1:0] uu, input logic [FW-1:0] vv);
        longint su;
        longint m;
        longint r;
        su = longint'($signed(uu));
        m  = (longint'(1) << FW) + longint'(vv);
        if (su >= 0) begin
            if (su > 40) return '1;
            r = m * (longint'(1) << su);
            if (r > longint'(32'hFFFF_FFFF) || su >= 21) return '1;
            return DW'(r);
        end
        if (su < -FW) return '0;
        return DW'(m / (longint'(1) << (-su)));
    endfunction

    task automatic send(input logic [DW-1:0] uu, input logic [FW-1:0] vv,
                        input logic last, input logic st2, input logic [DW-1:0] expv);
        int waited;
        waited = 0;
        bus.u         = uu;
        bus.v         = vv;
        bus.in_last   = last;
        bus.is_stage2 = st2;
        bus.in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 1000) begin
                flag("in_ready timeout");
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_acc++;
        if (st2) begin
            row_acc = row_acc + longint'(expv);
            if (row_acc > longint'(32'hFFFF_FFFF)) row_acc = longint'(32'hFFFF_FFFF);
            if (last) begin
                sum_q.push_back(DW'(row_acc));
                sum_cyc_q.push_back(cyc + 3);
                last_sum = DW'(row_acc);
                row_acc  = 0;
            end
        end else begin
            exp_q.push_back(expv);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 || sum_q.size() != 0) begin
            @(posedge clk);
            k++;
            if (k > 500) begin
                flag("drain timeout");
                exp_q.delete();
                sum_q.delete();
                sum_cyc_q.delete();
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic          hold;
        logic [DW-1:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("out_valid held", 32'(bus.out_valid), 32'd1);
                check("out_data held", bus.out_data, held);
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    hold = 1'b0;
                    if (exp_q.size() == 0) flag("unexpected out_valid");
                    else check("out_data", bus.out_data, exp_q.pop_front());
                end else begin
                    hold = 1'b1;
                    held = bus.out_data;
                end
            end else begin
                hold = 1'b0;
            end
            if (bus.sum_valid) begin
                if (sum_q.size() == 0) begin
                    flag("unexpected sum_valid");
                end else begin
                    check("sum_out", bus.sum_out, sum_q.pop_front());
                    check("sum_valid cycle", DW'(cyc), DW'(sum_cyc_q.pop_front()));
                end
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    logic [DW-1:0] dir_u[8];
    logic [FW-1:0] dir_v[8];
    logic [DW-1:0] dir_e[8];

    initial begin
        dir_u = '{32'd0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF6,
                  32'd21, 32'h7FFF_FFFF, 32'hFFFF_FFF5, 32'h8000_0000};
        dir_v = '{10'd0, 10'd512, 10'd0, 10'd1023, 10'd0, 10'd0, 10'd0, 10'd0};
        dir_e = '{32'h0000_0400, 32'h0000_3000, 32'h0000_0200, 32'h0000_0001,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        bus.in_valid  = 1'b0;
        bus.u         = '0;
        bus.v         = '0;
        bus.in_last   = 1'b0;
        bus.is_stage2 = 1'b0;
        bus.out_ready = 1'b1;
        fork
            monitor();
            rdy_gen();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset sum_valid", 32'(bus.sum_valid), 32'd0);
        check("reset sum_out", bus.sum_out, 32'd0);

        // Directed values, including saturation and underflow.
        for (int i = 0; i < 8; i++) send(dir_u[i], dir_v[i], 1'b0, 1'b0, dir_e[i]);
        drain();

        // Stage-2 row of four ones, then a row of two twos: both sum to 4.0.
        for (int i = 0; i < 4; i++) send(32'd0, 10'd0, i == 3, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 2; i++) send(32'd1, 10'd0, i == 1, 1'b1, 32'h0000_0800);
        drain();
        check("sum_out after rows", bus.sum_out, 32'h0000_1000);

        // Sum saturation.
        for (int i = 0; i < 3; i++) send(32'd20, 10'd1023, i == 2, 1'b1, 32'h7FF0_0000);
        drain();
        check("sum_out saturated", bus.sum_out, 32'hFFFF_FFFF);

        // Backpressure: out_ready low for five cycles while six elements are offered.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'(i), 10'(i * 100), 1'b0, 1'b0, ref_exp(32'(i), 10'(i * 100)));
            end
            begin
                int base;
                base = n_acc;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("accepts under backpressure", DW'(n_acc - base), 32'd2);
                check("in_ready under backpressure", 32'(bus.in_ready), 32'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-row discards the partial sum.
        send(32'd2, 10'd0, 1'b0, 1'b1, 32'h0000_1000);
        send(32'd2, 10'd0, 1'b0, 1'b1, 32'h0000_1000);
        repeat (4) @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        row_acc = 0;
        check("sum_out after reset", bus.sum_out, 32'd0);
        send(32'd0, 10'd0, 1'b1, 1'b1, 32'h0000_0400);
        drain();
        check("sum_out after aborted row", bus.sum_out, 32'h0000_0400);

        // Random stage-2 rows.
        for (int r = 0; r < 20; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [DW-1:0] uu;
                logic [FW-1:0] vv;
                uu = 32'($urandom_range(0, 32)) - 32'd12;
                vv = FW'($urandom_range(0, 1023));
                send(uu, vv, i == len - 1, 1'b1, ref_exp(uu, vv));
            end
        end
        drain();

        // Random stage-4 stream with random out_ready and input gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] uu;
            logic [FW-1:0] vv;
            if ($urandom_range(0, 9) == 0) uu = $urandom;
            else uu = 32'($urandom_range(0, 36)) - 32'd14;
            vv = FW'($urandom_range(0, 1023));
            send(uu, vv, 1'b0, 1'b0, ref_exp(uu, vv));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        check("sum_out held", bus.sum_out, last_sum);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
